regfile_sync: RTL and testbench
===============================

Name: regfile_sync

Overview:
- Clocked, parametrised successor to the combinational decode-stage register file.
- Two combinational read ports (rs/rt → A/B) and one clocked write port.
- Register 0 is optionally hardwired to zero.
- Has a hardware soft-clear sequencer: it sweeps the array to zero over DEPTH cycles, so the pipeline can re-initialise state without a full reset.

Parameters:
- DATA_WIDTH, 32, width of each register and of the write/read data.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH (local, not overridable).
- ZERO_REG, 1, when 1 index 0 always reads 0 and writes to it are discarded; when 0 index 0 is an ordinary register.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- rs  input  ADDR_WIDTH  read index, port A.
- rt  input  ADDR_WIDTH  read index, port B.
- write_reg  input  ADDR_WIDTH  write index.
- write_data  input  DATA_WIDTH  write data.
- reg_write  input  1  write enable, sampled at the rising clk edge.
- clear  input  1  soft-clear request, sampled at the rising clk edge.
- busy  output  1  high while the clear sweep runs.
- A  output  DATA_WIDTH  contents of REG[rs], combinational.
- B  output  DATA_WIDTH  contents of REG[rt], combinational.

Behaviour:
- Reset (rst_n=0, asynchronous): all DEPTH registers = 0, FSM = IDLE, sweep pointer = 0, busy = 0.
  - A and B therefore read 0 immediately, with no clock needed.
  - Reset asserted mid-sweep aborts the sweep at once and leaves the block in the same state as any other reset.
- Write: at the rising edge, REG[write_reg] <= write_data if all of the following hold:
  - reg_write=1;
  - busy=0;
  - !(ZERO_REG && write_reg==0).
- Read: A=REG[rs], B=REG[rt], purely combinational.
  - Without bypass, a write becomes visible on A/B after the edge that performs it (latency 1 edge).
  - rs==rt is legal; A and B are then equal.
- Zero register: with ZERO_REG=1, A=0 whenever rs==0 and B=0 whenever rt==0, regardless of array contents.
- Clear FSM, states IDLE and SWEEP:
  - IDLE: clear=1 at an edge → SWEEP with ptr=0. That same edge still performs any qualifying write; the sweep overwrites it later.
  - SWEEP: each edge writes REG[ptr] <= 0 and increments ptr.
    - The edge with ptr==DEPTH-1 writes the last entry, returns to IDLE and resets ptr to 0.
    - The sweep lasts exactly DEPTH edges.
  - busy = (state==SWEEP). It asserts after the edge that samples clear and deasserts after the final sweep edge.
  - reg_write while busy=1 is dropped silently and does not alter the sweep.
  - clear while busy=1 is ignored; there is no restart and no queueing.
  - Reads during SWEEP return current array contents: entries below ptr are already 0, the rest hold old values.
- Wrap-around: ptr is ADDR_WIDTH bits and is never allowed to wrap within a sweep.
- No X propagation: every register has a defined value from reset onward.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If reg_write=1, busy=0, the write is not to a discarded zero register, and rs==write_reg, then A=write_data combinationally in the same cycle. B follows the same rule using rt. The zero-register rule still has priority.
- Not defined: no forwarding; reads return array contents only (latency 1 edge).

Test Plan:
- Reset then reads: rst_n=0 asynchronously, then release; rs=5, rt=31 → A=0, B=0 with no clock edge required.
- Write/read with zero register: write 0xDEADBEEF to reg 7, then write 0x1234 to reg 0; rs=7, rt=0 → A=0xDEADBEEF, B=0. With ZERO_REG=0, B=0x1234.
- Bypass: same cycle reg_write=1, write_reg=3, write_data=0xA5A5A5A5, rs=3, with reg 3 previously holding 0x11.
  - REGFILE_BYPASS_EN defined: A=0xA5A5A5A5 before the edge.
  - REGFILE_BYPASS_EN undefined: A=0x11 before the edge, 0xA5A5A5A5 after it.
- Soft clear: fill all 32 regs with index+100, pulse clear.
  - busy is high for exactly 32 cycles.
  - Mid-sweep at ptr=10: reg 9 reads 0, reg 20 reads 120.
  - After busy falls: all regs read 0.
- Writes and clear while busy: during SWEEP, reg_write to reg 31 with 0xFFFF plus a second clear pulse → write dropped (reg 31 = 0 at end), sweep length unchanged at 32 cycles.
- Reset mid-sweep: assert rst_n=0 at ptr=12 → busy falls immediately, all regs 0, next clear starts a full 32-cycle sweep.

Source files
------------

// File: rtl/regfile_sync.sv
// regfile_sync: two combinational read ports, one clocked write port,
// optional hardwired-zero register 0 and a soft-clear sweep sequencer.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
module regfile_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  input  logic                  clear,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic                  wr_en;

  // Qualified write: enabled, not sweeping, and not aimed at a hardwired zero register
  always_comb begin
    wr_en = reg_write && (state_q == IDLE) && !((ZERO_REG != 0) && (write_reg == '0));
  end

  // Next-state logic: array update, clear FSM and sweep pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        // A write on the clear-sampling edge still lands; the sweep erases it later
        if (wr_en) regs_d[write_reg] = write_data;
        if (clear) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        regs_d[ptr_q] = '0;
        if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // State registers; reset clears the whole array and aborts any sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      regs_q  <= regs_d;
    end
  end

  // Combinational read ports; zero-register override has final priority
  always_comb begin
    A = regs_q[rs];
    B = regs_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (rs == write_reg)) A = write_data;
    if (wr_en && (rt == write_reg)) B = write_data;
`else
`endif
    if ((ZERO_REG != 0) && (rs == '0)) A = '0;
    if ((ZERO_REG != 0) && (rt == '0)) B = '0;
  end

  // Busy flag mirrors the sweep state
  always_comb begin
    busy = (state_q == SWEEP);
  end

endmodule

// File: tb/tb_regfile_sync.sv
// Scoreboard bench for regfile_sync: stimulus pushes expectations, a monitor
// process pops and compares them whenever a sample point is presented.
module tb_regfile_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rs = '0, rt = '0, write_reg = '0;
  logic [31:0] write_data = '0;
  logic        reg_write = 1'b0, clear = 1'b0;
  logic        busy, busy0;
  logic [31:0] a, b, a0, b0;

  regfile_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .write_reg(write_reg),
    .write_data(write_data), .reg_write(reg_write), .clear(clear),
    .busy(busy), .A(a), .B(b)
  );

  regfile_sync #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .write_reg(write_reg),
    .write_data(write_data), .reg_write(reg_write), .clear(clear),
    .busy(busy0), .A(a0), .B(b0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ea, eb, eb0;
    logic        ebusy;
    bit          ca, cb, cb0, cbusy;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  event  smp;
  int    checks = 0;
  int    errors = 0;

  // Monitor: on every sample point, drain the scoreboard and compare
  initial begin
    forever begin
      @(smp);
      while (exp_q.size() > 0) begin
        exp_t  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (e.ca) begin
          checks++;
          if (a !== e.ea) begin errors++; $display("FAIL %s A got %h exp %h", n, a, e.ea); end
        end
        if (e.cb) begin
          checks++;
          if (b !== e.eb) begin errors++; $display("FAIL %s B got %h exp %h", n, b, e.eb); end
        end
        if (e.cb0) begin
          checks++;
          if (b0 !== e.eb0) begin errors++; $display("FAIL %s B(zr0) got %h exp %h", n, b0, e.eb0); end
        end
        if (e.cbusy) begin
          checks++;
          if (busy !== e.ebusy) begin errors++; $display("FAIL %s busy got %b exp %b", n, busy, e.ebusy); end
        end
      end
    end
  end

  task automatic present(input string n, input exp_t e);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    -> smp;
    #1;
  endtask

  task automatic expect_ab(input string n, input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    e = '{ea: ea, eb: eb, eb0: '0, ebusy: 1'b0, ca: 1'b1, cb: 1'b1, cb0: 1'b0, cbusy: 1'b0};
    present(n, e);
  endtask

  task automatic expect_a(input string n, input logic [31:0] ea);
    exp_t e;
    e = '{ea: ea, eb: '0, eb0: '0, ebusy: 1'b0, ca: 1'b1, cb: 1'b0, cb0: 1'b0, cbusy: 1'b0};
    present(n, e);
  endtask

  task automatic expect_b0(input string n, input logic [31:0] eb0);
    exp_t e;
    e = '{ea: '0, eb: '0, eb0: eb0, ebusy: 1'b0, ca: 1'b0, cb: 1'b0, cb0: 1'b1, cbusy: 1'b0};
    present(n, e);
  endtask

  task automatic expect_busy(input string n, input logic eb);
    exp_t e;
    e = '{ea: '0, eb: '0, eb0: '0, ebusy: eb, ca: 1'b0, cb: 1'b0, cb0: 1'b0, cbusy: 1'b1};
    present(n, e);
  endtask

  task automatic check_len(input string n, input int got, input int exp_len);
    checks++;
    if (got != exp_len) begin
      errors++;
      $display("FAIL %s cycles got %0d exp %0d", n, got, exp_len);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = idx;
    write_data = d;
    cyc();
    reg_write  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout global time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;

    // Asynchronous reset, released before any clock edge
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    rs = 5'd5; rt = 5'd31;
    expect_ab("reset_read", 32'h0, 32'h0);
    expect_busy("reset_busy", 1'b0);

    // Write/read and zero register
    wr(5'd7, 32'hDEADBEEF);
    wr(5'd0, 32'h0000_1234);
    rs = 5'd7; rt = 5'd0;
    expect_ab("zero_reg", 32'hDEADBEEF, 32'h0);
    expect_b0("zero_reg_off", 32'h0000_1234);

    // Bypass vs. one-edge latency
    wr(5'd3, 32'h11);
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hA5A5A5A5;
    rs = 5'd3; rt = 5'd7;
`ifdef REGFILE_BYPASS_EN
    expect_ab("bypass_pre", 32'hA5A5A5A5, 32'hDEADBEEF);
`else
    expect_ab("bypass_pre", 32'h11, 32'hDEADBEEF);
`endif
    cyc();
    reg_write = 1'b0;
    expect_a("bypass_post", 32'hA5A5A5A5);
    // Zero register beats forwarding; write never reaches the edge
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h55; rs = 5'd0;
    expect_a("zero_vs_bypass", 32'h0);
    reg_write = 1'b0;

    // Fill all registers with index+100
    for (int i = 0; i < 32; i++) wr(5'(i), 32'(i + 100));
    rs = 5'd20; rt = 5'd31;
    expect_ab("fill", 32'd120, 32'd131);

    // Soft clear with mid-sweep probe at ptr=10
    pulse_clear();
    expect_busy("sweep_start", 1'b1);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == 10) begin
        rs = 5'd9; rt = 5'd20;
        expect_ab("mid_sweep", 32'h0, 32'd120);
        rs = 5'd10;
        expect_a("mid_sweep_ptr", 32'd110);
      end
      cyc();
      cnt++;
    end
    check_len("sweep_len", cnt, 32);
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i);
      expect_ab("after_clear", 32'h0, 32'h0);
    end
    expect_busy("sweep_end", 1'b0);

    // Writes and clear while busy are dropped/ignored
    wr(5'd31, 32'h77);
    wr(5'd5, 32'h55);
    pulse_clear();
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cnt == 3) begin
        reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hFFFF; clear = 1'b1;
      end else if (cnt == 5) begin
        reg_write = 1'b1; write_reg = 5'd2; write_data = 32'hFFFF; clear = 1'b0;
      end else begin
        reg_write = 1'b0; clear = 1'b0;
      end
      cyc();
      cnt++;
    end
    reg_write = 1'b0; clear = 1'b0;
    check_len("busy_sweep_len", cnt, 32);
    rs = 5'd31; rt = 5'd2;
    expect_ab("busy_write_drop", 32'h0, 32'h0);
    rs = 5'd5;
    expect_a("busy_sweep_r5", 32'h0);
    expect_busy("no_restart", 1'b0);

    // Reset in the middle of a sweep
    wr(5'd15, 32'h99);
    wr(5'd20, 32'h20);
    pulse_clear();
    for (int i = 0; i < 12; i++) cyc();
    rst_n = 1'b0;
    rs = 5'd15; rt = 5'd20;
    expect_ab("rst_mid_regs", 32'h0, 32'h0);
    expect_busy("rst_mid_busy", 1'b0);
    rst_n = 1'b1;
    cyc();
    expect_busy("rst_release_idle", 1'b0);
    pulse_clear();
    cnt = 0;
    while (busy && cnt < 100) begin
      cyc();
      cnt++;
    end
    check_len("post_rst_sweep_len", cnt, 32);

    // Write works again after the sweep
    wr(5'd9, 32'hCAFE0009);
    rs = 5'd9; rt = 5'd9;
    expect_ab("post_sweep_write", 32'hCAFE0009, 32'hCAFE0009);

    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
